// File: rtl/alu_mul_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_mul_seq_pkg
//   Shared definitions for the Hack-ALU based blocks.
//   - ALU_W      : data width of the Hack ALU (16 bits)
//   - OP_*       : 6-bit ALU control codes, packed as {zx,nx,zy,ny,f,no}.
//                  The CPU decoder can reuse these codes directly.
//   - state_e    : 2-bit state encodings of the multiplier controller
//   - alu_op_is_defined() : returns 1 for the 18 documented Hack ALU codes
// -----------------------------------------------------------------------------
package alu_mul_seq_pkg;

    localparam int ALU_W = 16;

    // Control codes {zx,nx,zy,ny,f,no}
    localparam logic [5:0] OP_ZERO = 6'b101010;  // 0
    localparam logic [5:0] OP_ONE  = 6'b111111;  // 1
    localparam logic [5:0] OP_NEG1 = 6'b111010;  // -1
    localparam logic [5:0] OP_X    = 6'b001100;  // x
    localparam logic [5:0] OP_Y    = 6'b110000;  // y
    localparam logic [5:0] OP_NOTX = 6'b001101;  // !x
    localparam logic [5:0] OP_NOTY = 6'b110001;  // !y
    localparam logic [5:0] OP_NEGX = 6'b001111;  // -x
    localparam logic [5:0] OP_NEGY = 6'b110011;  // -y
    localparam logic [5:0] OP_XP1  = 6'b011111;  // x+1
    localparam logic [5:0] OP_YP1  = 6'b110111;  // y+1
    localparam logic [5:0] OP_XM1  = 6'b001110;  // x-1
    localparam logic [5:0] OP_YM1  = 6'b110010;  // y-1
    localparam logic [5:0] OP_ADD  = 6'b000010;  // x+y
    localparam logic [5:0] OP_SUB  = 6'b010011;  // x-y
    localparam logic [5:0] OP_YMX  = 6'b000111;  // y-x
    localparam logic [5:0] OP_AND  = 6'b000000;  // x&y
    localparam logic [5:0] OP_OR   = 6'b010101;  // x|y

    // Multiplier controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DBL  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // True when op is one of the documented Hack ALU functions; a CPU
    // decoder can use this to flag illegal compute fields.
    function automatic logic alu_op_is_defined(input logic [5:0] op);
        logic ok;
        case (op)
            OP_ZERO, OP_ONE, OP_NEG1, OP_X, OP_Y, OP_NOTX,
            OP_NOTY, OP_NEGX, OP_NEGY, OP_XP1, OP_YP1, OP_XM1,
            OP_YM1, OP_ADD, OP_SUB, OP_YMX, OP_AND, OP_OR: ok = 1'b1;
            default:                                         ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_mul_seq_alu.sv
// -----------------------------------------------------------------------------
// alu_mul_seq_alu
//   Combinational Hack ALU datapath (the only adder in the multiplier).
//   Ports:
//     x_i, y_i   : operands, WIDTH bits
//     zx_i, nx_i : zero / invert x
//     zy_i, ny_i : zero / invert y
//     f_i        : 1 = x+y, 0 = x&y
//     no_i       : invert result
//     out_o      : result, WIDTH bits
//   The zr/ng status flags are not produced here: the multiplier derives
//   its flags from its registered product instead.
// -----------------------------------------------------------------------------
module alu_mul_seq_alu
    import alu_mul_seq_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             zx_i,
    input  logic             nx_i,
    input  logic             zy_i,
    input  logic             ny_i,
    input  logic             f_i,
    input  logic             no_i,
    output logic [WIDTH-1:0] out_o
);

    logic [WIDTH-1:0] x_z_s;
    logic [WIDTH-1:0] x_n_s;
    logic [WIDTH-1:0] y_z_s;
    logic [WIDTH-1:0] y_n_s;
    logic [WIDTH-1:0] fn_s;

    // Operand preset: optional zeroing then optional inversion.
    always_comb begin
        if (zx_i) begin
            x_z_s = {WIDTH{1'b0}};
        end else begin
            x_z_s = x_i;
        end
        if (nx_i) begin
            x_n_s = ~x_z_s;
        end else begin
            x_n_s = x_z_s;
        end
        if (zy_i) begin
            y_z_s = {WIDTH{1'b0}};
        end else begin
            y_z_s = y_i;
        end
        if (ny_i) begin
            y_n_s = ~y_z_s;
        end else begin
            y_n_s = y_z_s;
        end
    end

    // Function select and output inversion; the sum wraps modulo 2^WIDTH.
    always_comb begin
        if (f_i) begin
            fn_s = x_n_s + y_n_s;
        end else begin
            fn_s = x_n_s & y_n_s;
        end
        if (no_i) begin
            out_o = ~fn_s;
        end else begin
            out_o = fn_s;
        end
    end

endmodule

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
//   Sequential shift-and-add 16-bit multiplier that time-shares one Hack ALU
//   as its only adder, one ALU operation per clock.
//   Ports:
//     clk      : clock, rising edge
//     rst_n    : synchronous active-low reset
//     start    : request, sampled only in IDLE
//     a, b     : multiplicand / multiplier (two's complement), sampled with start
//     busy     : high from the accept edge until done deasserts
//     done     : one-cycle pulse, product valid
//     product  : low WIDTH bits of a*b, held until the next result
//     zr, ng   : product == 0, product sign bit
//   Operation:
//     ADD : acc   <= acc + mcand           (current multiplier bit is 1)
//     DBL : mcand <= mcand + mcand, mult >>= 1
//   The low WIDTH bits of a two's complement product do not depend on
//   operand signedness, so b is simply walked as an unsigned bit string.
//   Only WIDTH == 16 (the ALU width) is supported.
// -----------------------------------------------------------------------------
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             zr,
    output logic             ng
);

    state_e           state_q,   state_d;
    logic [WIDTH-1:0] acc_q,     acc_d;
    logic [WIDTH-1:0] mcand_q,   mcand_d;
    logic [WIDTH-1:0] mult_q,    mult_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    logic [5:0]       alu_op_s;
    logic [WIDTH-1:0] alu_x_s;
    logic [WIDTH-1:0] alu_y_s;
    logic [WIDTH-1:0] alu_out_s;
    logic [WIDTH-1:0] mult_shr_s;

    alu_mul_seq_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .x_i   (alu_x_s),
        .y_i   (alu_y_s),
        .zx_i  (alu_op_s[5]),
        .nx_i  (alu_op_s[4]),
        .zy_i  (alu_op_s[3]),
        .ny_i  (alu_op_s[2]),
        .f_i   (alu_op_s[1]),
        .no_i  (alu_op_s[0]),
        .out_o (alu_out_s)
    );

    // Next-state, datapath steering and output register inputs.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mult_d     = mult_q;
        product_d  = product_q;
        busy_d     = busy_q;
        done_d     = done_q;
        alu_op_s   = OP_ADD;
        alu_x_s    = {WIDTH{1'b0}};
        alu_y_s    = {WIDTH{1'b0}};
        mult_shr_s = mult_q >> 1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = {WIDTH{1'b0}};
                    mcand_d = a;
                    mult_d  = b;
                    busy_d  = 1'b1;
                    if (b == {WIDTH{1'b0}}) begin
                        // acc is only being cleared on this edge, so the
                        // zero product is loaded directly.
                        state_d   = ST_DONE;
                        product_d = {WIDTH{1'b0}};
                        done_d    = 1'b1;
                    end else if (b[0]) begin
                        state_d = ST_ADD;
                    end else begin
                        state_d = ST_DBL;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ADD: begin
                alu_x_s = acc_q;
                alu_y_s = mcand_q;
                acc_d   = alu_out_s;
                state_d = ST_DBL;
            end

            ST_DBL: begin
                alu_x_s = mcand_q;
                alu_y_s = mcand_q;
                mcand_d = alu_out_s;
                mult_d  = mult_shr_s;
                if (mult_shr_s == {WIDTH{1'b0}}) begin
                    // acc is final: DBL never touches it.
                    state_d   = ST_DONE;
                    product_d = acc_q;
                    done_d    = 1'b1;
                end else if (mult_q[1]) begin
                    state_d = ST_ADD;
                end else begin
                    state_d = ST_DBL;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= {WIDTH{1'b0}};
            mcand_q   <= {WIDTH{1'b0}};
            mult_q    <= {WIDTH{1'b0}};
            product_q <= {WIDTH{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mult_q    <= mult_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
    assign zr      = (product_q == {WIDTH{1'b0}});
    assign ng      = product_q[WIDTH-1];

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
Multi-cycle 16-bit multiplier controller that time-shares one instance of the team's Hack ALU as its only adder. It performs shift-and-add multiplication by driving the ALU control pins (zx,nx,zy,ny,f,no) and its x/y operands from an FSM, one ALU operation per cycle. It is the first clocked block layered on the combinational ALU, and feeds a later CPU "multiply" extension.

Parameters:
WIDTH, 16, operand/product width; must equal the ALU data width; no other value is supported.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  synchronous active-low reset
start  input  1  request pulse; sampled only in IDLE
a  input  WIDTH  multiplicand, two's complement, sampled with start
b  input  WIDTH  multiplier, two's complement, sampled with start
busy  output  1  high from the start-accept edge until done deasserts
done  output  1  one-cycle pulse; product valid
product  output  WIDTH  low WIDTH bits of a*b; held until the next accepted start
zr  output  1  product == 0 (combinational from the product register)
ng  output  1  product[WIDTH-1]

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a rising edge): state=IDLE, busy=0, done=0, product=0, so zr=1 and ng=0. Reset overrides start in the same cycle. Reset mid-operation aborts immediately and discards partial results.
- Internal registers:
  - acc (product accumulator)
  - mcand (shifted multiplicand)
  - mult (remaining multiplier bits)
- ALU usage: only "x+y" is used (zx=0 nx=0 zy=0 ny=0 f=1 no=0). In IDLE and DONE, the ALU controls stay at this code and x=y=0.
- States:
  - IDLE: if start, then acc<=0, mcand<=a, mult<=b, busy<=1. Next state: DONE if b==0, ADD if b[0]==1, else DBL. start is ignored in every other state.
  - ADD: ALU x=acc, y=mcand. acc<=alu_out. Next state: DBL.
  - DBL: ALU x=mcand, y=mcand. mcand<=alu_out, mult<=mult>>1 (logical). Next state: DONE if (mult>>1)==0, ADD if mult[1]==1, else DBL.
  - DONE: product<=acc is registered on entry, so done=1 and product are visible in the same cycle. busy stays 1. Next state: IDLE, with busy<=0 and done<=0.
- Latency: N = popcount(b) + (index of highest set bit of b + 1) op cycles. done is high during the cycle after the N-th op edge. For b=0, N=0 and done follows the accept edge directly. Worst case b=0xFFFF gives N=32.
- Arithmetic: all additions wrap modulo 2^WIDTH. The result equals the low WIDTH bits of the signed product; no overflow flag is produced.
- product, zr and ng change only on entry to DONE or on reset. They remain stable while busy.

Decomposition:
- Shared header alu_ops.vh holds:
  - the 6-bit ALU control-code localparams (OP_ADD=6'b000010, OP_ZERO, etc.) for reuse by later CPU blocks
  - the 2-bit state encodings IDLE/ADD/DBL/DONE
- Exactly one sub-module: a single ALU instance inside alu_mul_seq. No additional adder may be inferred.

Test Plan:
- Reset: rst_n=0 for 2 cycles with start=1 → busy=0, done=0, product=0, zr=1, ng=0. No operation starts.
- a=9, b=15, start for 1 cycle → busy rises. After the 8th op edge, done=1 for exactly one cycle with product=135, zr=0, ng=0. busy falls on the next edge.
- a=-3, b=5 → N=5, product=-15 (0xFFF1), ng=1. Then a=1234, b=0 → done on the cycle after accept, product=0, zr=1.
- a=0x0100, b=0x0100 → wrap-around, product=0, zr=1, N=10. Then a=1, b=0xFFFF → N=32, product=0xFFFF (-1), ng=1.
- start held high throughout the a=7, b=6 operation, and new a/b values applied while busy → ignored. Result is 42. The next start is accepted only on the edge after done.
- rst_n pulsed low mid-operation (op cycle 3 of a=9, b=15) → IDLE and the reset outputs on the next edge. No done pulse. A fresh start with a=2, b=3 gives 6.
